// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and constants for the fifo write-port arbiter and its helpers.
package fifo_write_arbiter_pkg;

  // Arbiter control states: IDLE arbitrates, BUSY waits for the fifo's ack.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of the optional completed-transfer counter.
  localparam int unsigned STATS_COUNT_WIDTH = 32;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set valid bit at or above rr_ptr_i,
// wrapping from NUM_REQUESTER-1 back to 0.
module rr_priority_select #(
  parameter int unsigned NUM_REQUESTER      = 4,
  parameter int unsigned NUM_REQUESTER_LOG2 = 2
) (
  input  logic [NUM_REQUESTER-1:0]      valid_i,
  input  logic [NUM_REQUESTER_LOG2-1:0] rr_ptr_i,
  output logic [NUM_REQUESTER_LOG2-1:0] winner_c_o,
  output logic                          any_valid_c_o
);

  logic [2*NUM_REQUESTER-1:0] doubled;
  logic [NUM_REQUESTER-1:0]   rotated;
  int unsigned                offset;
  int unsigned                sum;

  // Rotate so rr_ptr sits at bit 0, find the lowest set bit, rotate the index back.
  always_comb begin
    doubled       = {valid_i, valid_i} >> rr_ptr_i;
    rotated       = doubled[NUM_REQUESTER-1:0];
    offset        = 0;
    any_valid_c_o = 1'b0;
    for (int i = 0; i < NUM_REQUESTER; i++) begin
      if (!any_valid_c_o && rotated[i]) begin
        any_valid_c_o = 1'b1;
        offset        = 32'(i);
      end
    end
    sum = 32'(rr_ptr_i) + offset;
    if (sum >= NUM_REQUESTER) begin
      sum = sum - NUM_REQUESTER;
    end
    winner_c_o = NUM_REQUESTER_LOG2'(sum);
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo_queue write port among NUM_REQUESTER
// producers. The winner's entry is captured into a registered output and held
// until the fifo acks it; the winner gets a one-cycle ack pulse at grant time.
// Optional build macro FIFO_WRITE_ARBITER_STATS_EN adds grant_count_out and
// contention_out.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTER              = 4,
  parameter int unsigned NUM_REQUESTER_LOG2         = 2,
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 32
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  input  logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
  input  logic [NUM_REQUESTER-1:0]                            request_valid_packed_in,
  output logic [NUM_REQUESTER-1:0]                            issue_ack_packed_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               request_out,
  output logic                                                request_valid_out,
  input  logic                                                issue_ack_in,
  output logic [NUM_REQUESTER_LOG2-1:0]                       grant_id_out
`ifdef FIFO_WRITE_ARBITER_STATS_EN
  ,
  output logic [STATS_COUNT_WIDTH-1:0]                        grant_count_out,
  output logic                                                contention_out
`endif
);

  localparam int unsigned W = SINGLE_ENTRY_WIDTH_IN_BITS;

  arb_state_e                    state_q, state_d;
  logic [NUM_REQUESTER_LOG2-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0]                  request_q, request_d;
  logic                          valid_q, valid_d;
  logic [NUM_REQUESTER-1:0]      ack_q, ack_d;
  logic [NUM_REQUESTER_LOG2-1:0] grant_id_q, grant_id_d;

  logic [NUM_REQUESTER_LOG2-1:0] sel_winner;
  logic                          sel_any_valid;
  logic [W-1:0]                  entry_arr [NUM_REQUESTER];

  // Unpack the flat entry bus into one word per requester.
  for (genvar g = 0; g < NUM_REQUESTER; g++) begin : g_unpack
    assign entry_arr[g] = request_packed_in[g*W +: W];
  end

  rr_priority_select #(
    .NUM_REQUESTER      (NUM_REQUESTER),
    .NUM_REQUESTER_LOG2 (NUM_REQUESTER_LOG2)
  ) u_rr_priority_select (
    .valid_i       (request_valid_packed_in),
    .rr_ptr_i      (rr_ptr_q),
    .winner_c_o    (sel_winner),
    .any_valid_c_o (sel_any_valid)
  );

  // State and datapath registers; reset drops any in-flight entry.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      request_q  <= '0;
      valid_q    <= 1'b0;
      ack_q      <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      request_q  <= request_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Next-state: grant in IDLE, wait for the fifo ack in BUSY, then advance the pointer.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    request_d  = request_q;
    valid_d    = valid_q;
    ack_d      = '0;
    grant_id_d = grant_id_q;
    case (state_q)
      IDLE: begin
        if (sel_any_valid) begin
          request_d  = entry_arr[sel_winner];
          valid_d    = 1'b1;
          grant_id_d = sel_winner;
          ack_d      = NUM_REQUESTER'(1) << sel_winner;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (issue_ack_in) begin
          request_d = '0;
          valid_d   = 1'b0;
          rr_ptr_d  = (grant_id_q == NUM_REQUESTER_LOG2'(NUM_REQUESTER - 1)) ?
                      '0 : grant_id_q + NUM_REQUESTER_LOG2'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign issue_ack_packed_out = ack_q;
  assign request_out          = request_q;
  assign request_valid_out    = valid_q;
  assign grant_id_out         = grant_id_q;

`ifdef FIFO_WRITE_ARBITER_STATS_EN
  logic [STATS_COUNT_WIDTH-1:0] grant_count_q, grant_count_d;
  logic                         contention_q, contention_d;

  // Statistics registers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      grant_count_q <= '0;
      contention_q  <= 1'b0;
    end else begin
      grant_count_q <= grant_count_d;
      contention_q  <= contention_d;
    end
  end

  // Saturating count of completed transfers; flag arbitrations with 2+ valids.
  always_comb begin
    grant_count_d = grant_count_q;
    contention_d  = 1'b0;
    if (state_q == BUSY && issue_ack_in && grant_count_q != '1) begin
      grant_count_d = grant_count_q + STATS_COUNT_WIDTH'(1);
    end
    if (state_q == IDLE &&
        (request_valid_packed_in & (request_valid_packed_in - NUM_REQUESTER'(1))) != '0) begin
      contention_d = 1'b1;
    end
  end

  assign grant_count_out = grant_count_q;
  assign contention_out  = contention_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus a
// randomized run against a transaction-level round-robin reference.
module tb_fifo_write_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned LOG2 = 2;
  localparam int unsigned W    = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] req_packed;
  logic [N-1:0]   pv;
  logic [N-1:0]   ack_packed;
  logic [W-1:0]   req_out;
  logic           req_valid_out;
  logic           issue_ack;
  logic [LOG2-1:0] grant_id;
  logic [W-1:0]   pe [N];
`ifdef FIFO_WRITE_ARBITER_STATS_EN
  logic [31:0]    grant_count;
  logic           contention;
`endif

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) req_packed[i*W +: W] = pe[i];
  end

  fifo_write_arbiter #(
    .NUM_REQUESTER              (N),
    .NUM_REQUESTER_LOG2         (LOG2),
    .SINGLE_ENTRY_WIDTH_IN_BITS (W)
  ) dut (
    .clk_in                  (clk),
    .reset_in                (rst),
    .request_packed_in       (req_packed),
    .request_valid_packed_in (pv),
    .issue_ack_packed_out    (ack_packed),
    .request_out             (req_out),
    .request_valid_out       (req_valid_out),
    .issue_ack_in            (issue_ack),
    .grant_id_out            (grant_id)
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    ,
    .grant_count_out         (grant_count),
    .contention_out          (contention)
`endif
  );

  // Reference rule: first pending requester at or after the pointer, modulo N.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[LOG2'((p + i) % N)]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pv = '0; issue_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pv = '0; issue_ack = 1'b0;
    step(); step();
    checks++; if (ack_packed !== '0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack_packed); end
    checks++; if (req_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", req_valid_out); end
    checks++; if (req_out !== '0) begin errors++; $display("FAIL reset_req got=%h exp=0", req_out); end
    checks++; if (grant_id !== '0) begin errors++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
    rst = 1'b0; m_ptr = 0;
    step();
  endtask

  task automatic test_single();
    pe[2] = 32'hA5A5_0002; pv = 4'b0100;
    step();
    checks++; if (ack_packed !== 4'b0100) begin errors++; $display("FAIL single_ack got=%b exp=0100", ack_packed); end
    checks++; if (req_out !== 32'hA5A5_0002) begin errors++; $display("FAIL single_req got=%h exp=a5a50002", req_out); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_gid got=%0d exp=2", grant_id); end
    pv = '0;
    step();
    checks++; if (ack_packed !== '0) begin errors++; $display("FAIL single_ack_width got=%b exp=0", ack_packed); end
    checks++; if (req_valid_out !== 1'b1) begin errors++; $display("FAIL single_valid_held got=%b exp=1", req_valid_out); end
    issue_ack = 1'b1;
    step();
    issue_ack = 1'b0;
    checks++; if (req_valid_out !== 1'b0) begin errors++; $display("FAIL single_valid_drop got=%b exp=0", req_valid_out); end
    checks++; if (req_out !== '0) begin errors++; $display("FAIL single_req_clear got=%h exp=0", req_out); end
    m_ptr = 3;
  endtask

  task automatic test_wrap();
    pe[0] = 32'h0000_1000; pe[3] = 32'h0000_3003; pv = 4'b1001;
    step();
    checks++; if (ack_packed !== 4'b1000) begin errors++; $display("FAIL wrap_first_ack got=%b exp=1000", ack_packed); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL wrap_first_gid got=%0d exp=3", grant_id); end
    pv = 4'b0001; issue_ack = 1'b1;
    step();
    issue_ack = 1'b0;
    step();
    checks++; if (ack_packed !== 4'b0001) begin errors++; $display("FAIL wrap_second_ack got=%b exp=0001", ack_packed); end
    checks++; if (req_out !== 32'h0000_1000) begin errors++; $display("FAIL wrap_second_req got=%h exp=00001000", req_out); end
    pv = '0; issue_ack = 1'b1;
    step();
    issue_ack = 1'b0;
    m_ptr = 1;
  endtask

  task automatic test_idle_ack();
    pv = '0; issue_ack = 1'b1;
    repeat (3) step();
    issue_ack = 1'b0;
    checks++; if (req_valid_out !== 1'b0) begin errors++; $display("FAIL idle_ack_valid got=%b exp=0", req_valid_out); end
    checks++; if (ack_packed !== '0) begin errors++; $display("FAIL idle_ack_acks got=%b exp=0", ack_packed); end
  endtask

  task automatic test_all_valid();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) pe[i] = $urandom;
    pv = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      logic [W-1:0] data;
      data = pe[order[t]];
      step();
      checks++; if (ack_packed !== N'(1) << order[t]) begin errors++; $display("FAIL allv_ack[%0d] got=%b exp_idx=%0d", t, ack_packed, order[t]); end
      checks++; if (req_out !== data) begin errors++; $display("FAIL allv_req[%0d] got=%h exp=%h", t, req_out, data); end
      pe[order[t]] = $urandom;
      issue_ack = 1'b1;
      step();
      issue_ack = 1'b0;
      checks++; if (req_valid_out !== 1'b0 || ack_packed !== '0) begin errors++; $display("FAIL allv_gap[%0d] got_valid=%b got_ack=%b exp=0", t, req_valid_out, ack_packed); end
    end
    pv = '0;
    m_ptr = 1;
  endtask

  task automatic test_full();
    int exp;
    int bad = 0;
    logic [W-1:0] data;
    pe[1] = 32'h1111_0001; pe[2] = 32'h2222_0002; pv = 4'b0110;
    exp = pick(pv, m_ptr);
    data = pe[exp];
    step();
    checks++; if (grant_id !== LOG2'(exp)) begin errors++; $display("FAIL full_gid got=%0d exp=%0d", grant_id, exp); end
    pv[exp] = 1'b0;
    for (int i = 0; i < N; i++) if (i != exp) pe[i] = $urandom;
    for (int c = 0; c < 20; c++) begin
      step();
      if (req_valid_out !== 1'b1 || req_out !== data || ack_packed !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_hold got=%0d_bad_cycles exp=0 last_req=%h exp_req=%h", bad, req_out, data); end
    data = pe[pick(pv, exp + 1)];
    issue_ack = 1'b1;
    step();
    issue_ack = 1'b0;
    checks++; if (req_valid_out !== 1'b0) begin errors++; $display("FAIL full_release got=%b exp=0", req_valid_out); end
    step();
    checks++; if (req_out !== data || req_valid_out !== 1'b1) begin errors++; $display("FAIL full_next_req got=%h exp=%h", req_out, data); end
    pv = '0; issue_ack = 1'b1;
    step();
    issue_ack = 1'b0;
    m_ptr = 3;
  endtask

  task automatic test_reset_busy();
    do_reset();
    pe[1] = 32'hB0B0_0001; pe[2] = 32'hB0B0_0002; pe[3] = 32'hB0B0_0003;
    pv = 4'b0010;
    step();
    pv = '0; issue_ack = 1'b1;
    step();
    issue_ack = 1'b0;
    pv = 4'b0100;
    step();
    checks++; if (ack_packed !== 4'b0100) begin errors++; $display("FAIL rstb_pre_ack got=%b exp=0100", ack_packed); end
    #3 rst = 1'b1;
    #1;
    checks++; if (req_valid_out !== 1'b0 || req_out !== '0 || ack_packed !== '0 || grant_id !== '0)
      begin errors++; $display("FAIL rstb_async got_valid=%b got_req=%h got_ack=%b got_gid=%0d exp=all0", req_valid_out, req_out, ack_packed, grant_id); end
    pv = 4'b1010;
    step();
    rst = 1'b0;
    step();
    checks++; if (ack_packed !== 4'b0010) begin errors++; $display("FAIL rstb_fresh_ack got=%b exp=0010", ack_packed); end
    checks++; if (req_out !== 32'hB0B0_0001) begin errors++; $display("FAIL rstb_fresh_req got=%h exp=b0b00001", req_out); end
    pv = 4'b1000; issue_ack = 1'b1;
    step();
    issue_ack = 1'b0; pv = '0;
    m_ptr = 2;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int exp;
      int d;
      logic [W-1:0] data;
      if (pv == '0) begin
        pv = N'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < N; i++) pe[i] = $urandom;
      end
      exp = pick(pv, m_ptr);
      data = pe[exp];
      step();
      checks++; if (ack_packed !== N'(1) << exp) begin errors++; $display("FAIL rnd_ack[%0d] got=%b exp_idx=%0d", t, ack_packed, exp); end
      checks++; if (grant_id !== LOG2'(exp) || req_out !== data || req_valid_out !== 1'b1)
        begin errors++; $display("FAIL rnd_grant[%0d] got_gid=%0d got_req=%h exp_gid=%0d exp_req=%h", t, grant_id, req_out, exp, data); end
      if ($urandom_range(0, 1) == 0) pv[exp] = 1'b0;
      else pe[exp] = $urandom;
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && i != exp && $urandom_range(0, 3) == 0) begin
          pe[i] = $urandom; pv[i] = 1'b1;
        end
      end
      d = $urandom_range(0, 3);
      for (int c = 0; c < d; c++) begin
        step();
        checks++; if (req_valid_out !== 1'b1 || req_out !== data || ack_packed !== '0)
          begin errors++; $display("FAIL rnd_wait[%0d] got_valid=%b got_req=%h got_ack=%b exp_req=%h", t, req_valid_out, req_out, ack_packed, data); end
      end
      issue_ack = 1'b1;
      step();
      issue_ack = 1'b0;
      checks++; if (req_valid_out !== 1'b0 || req_out !== '0) begin errors++; $display("FAIL rnd_done[%0d] got_valid=%b got_req=%h exp=0", t, req_valid_out, req_out); end
      m_ptr = (exp + 1) % N;
    end
    pv = '0;
  endtask

`ifdef FIFO_WRITE_ARBITER_STATS_EN
  task automatic test_stats();
    logic [N-1:0] tbl [5] = '{4'b0001, 4'b0110, 4'b0100, 4'b1001, 4'b0001};
    int pulses = 0;
    do_reset();
    checks++; if (grant_count !== 32'd0) begin errors++; $display("FAIL stats_reset got=%h exp=0", grant_count); end
    for (int t = 0; t < 5; t++) begin
      pv = tbl[t];
      step();
      if (contention === 1'b1) pulses++;
      checks++; if (contention !== ($countones(tbl[t]) > 1)) begin errors++; $display("FAIL stats_cont[%0d] got=%b", t, contention); end
      pv = '0; issue_ack = 1'b1;
      step();
      issue_ack = 1'b0;
      if (contention === 1'b1) pulses++;
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL stats_pulses got=%0d exp=2", pulses); end
    checks++; if (grant_count !== 32'd5) begin errors++; $display("FAIL stats_count got=%0d exp=5", grant_count); end
    force dut.grant_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.grant_count_q;
    for (int t = 0; t < 3; t++) begin
      pv = 4'b0001;
      step();
      pv = '0; issue_ack = 1'b1;
      step();
      issue_ack = 1'b0;
    end
    checks++; if (grant_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_sat got=%h exp=ffffffff", grant_count); end
  endtask
`endif

  initial begin
    rst = 1'b1; pv = '0; issue_ack = 1'b0;
    for (int i = 0; i < N; i++) pe[i] = '0;
    test_reset();
    test_single();
    test_wrap();
    test_idle_ack();
    test_all_valid();
    test_full();
    test_reset_busy();
    test_random();
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of one fifo_queue among NUM_REQUESTER upstream producers. It latches one winner's entry into a registered output and presents it downstream with the codebase request/valid/ack handshake. It returns a one-cycle ack pulse to the winner. The block sits directly in front of fifo_queue's request_in/request_valid_in/issue_ack_out port.

Parameters:
NUM_REQUESTER, 4, number of upstream producers (>=2, power of two not required)
NUM_REQUESTER_LOG2, 2, width of grant index (ceil log2 of NUM_REQUESTER)
SINGLE_ENTRY_WIDTH_IN_BITS, 32, width of one entry

Ports:
clk_in  input  1  clock, all state on rising edge
reset_in  input  1  asynchronous, active-high reset
request_packed_in  input  NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS  entries; requester i occupies bits [i*W +: W]
request_valid_packed_in  input  NUM_REQUESTER  per-requester valid, held until acked
issue_ack_packed_out  output  NUM_REQUESTER  per-requester one-cycle ack pulse (registered)
request_out  output  SINGLE_ENTRY_WIDTH_IN_BITS  entry to fifo_queue request_in
request_valid_out  output  1  to fifo_queue request_valid_in
issue_ack_in  input  1  from fifo_queue issue_ack_out, one-cycle pulse
grant_id_out  output  NUM_REQUESTER_LOG2  index of requester owning request_out (valid while request_valid_out=1)

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, request_out=0, request_valid_out=0, issue_ack_packed_out=0, grant_id_out=0. An in-flight entry is dropped and must not be re-presented.
- States: IDLE, BUSY.
- IDLE, no valid: hold. All outputs idle, acks 0.
- IDLE, any valid: pick the first set bit searching from rr_ptr upward, wrapping at NUM_REQUESTER-1 to 0.
  - Next edge: request_out<=entry[winner], request_valid_out<=1, grant_id_out<=winner, issue_ack_packed_out<=onehot(winner), go to BUSY.
- BUSY: issue_ack_packed_out<=0 every cycle, so the ack is exactly one cycle wide. request_out and grant_id_out hold.
  - When issue_ack_in=1: request_valid_out<=0, request_out<=0, rr_ptr<=winner+1 (winner=NUM_REQUESTER-1 -> 0), go to IDLE.
- Minimum spacing: 2 cycles per transfer (IDLE->BUSY->IDLE). This matches fifo_queue accepting at most one write per two cycles.
- Requester contract: deassert valid (or present the next entry) in the cycle after its ack pulse. The arbiter never re-samples it earlier, because it spends at least one cycle in BUSY.
- issue_ack_in while in IDLE: ignored, no state change.
- Downstream full: fifo_queue withholds issue_ack_in. The arbiter stays in BUSY indefinitely with valid held. No timeout.
- Simultaneous valids: exactly one winner per arbitration; the others wait. The pointer update guarantees each waiting requester is served within NUM_REQUESTER grants.
- Entries are captured at grant time; later changes on request_packed_in do not affect request_out.

Optional Feature:
- Macro: FIFO_WRITE_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_count_out, 32 bits: count of completed transfers (BUSY with issue_ack_in=1). Saturates at 32'hFFFF_FFFF. Reset to 0.
  - Adds output contention_out, 1 bit: registered; 1 for the cycle after an IDLE arbitration in which more than one valid was set.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package: state encodings (IDLE, BUSY), STATS_COUNT_WIDTH=32.
- One natural sub-module: rr_priority_select. It is combinational; inputs are the valid vector and rr_ptr, outputs are the winner index and an any_valid flag. It is reusable by other arbiters in the codebase.

Test Plan:
- Single requester, valid[2]=1, entry=32'hA5A5_0002, fifo acks 1 cycle later -> ack_out=4'b0100 for 1 cycle, request_out=A5A5_0002, grant_id=2, valid drops after issue_ack_in, rr_ptr=3.
- All 4 valid continuously, immediate acks -> grant order 0,1,2,3,0 with one transfer per 2 cycles and no requester skipped.
- rr_ptr=3, valid=4'b1001 -> grant 3, then 0; wrap verified.
- Downstream full: issue_ack_in held 0 for 20 cycles -> request_valid_out=1 and request_out stable throughout, no further upstream acks; first ack releases.
- Reset asserted while in BUSY -> all outputs 0 asynchronously; after release, a held valid[1] is granted fresh with rr_ptr=0.
- STATS_EN: 5 transfers, two of which arbitrated with 2+ valids -> grant_count_out=5, contention_out pulsed twice; force count to FFFF_FFFE, 3 transfers -> stays FFFF_FFFF.
